// File: rtl/bayer_demosaic.sv
// rtl/bayer_demosaic.sv - Bilinear Bayer-to-RGB demosaic, 3x3 window over two line buffers plus current row
module bayer_demosaic #(
   parameter int DATA_W  = 8,
   parameter int SIZE_X  = 640,
   parameter int SIZE_Y  = 480,
   parameter int PATTERN = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_sof,
   input  logic [DATA_W-1:0] raw,
   output logic              in_ready,
   output logic              out_valid,
   output logic              out_sof,
   output logic              out_eol,
   output logic [DATA_W-1:0] red,
   output logic [DATA_W-1:0] green,
   output logic [DATA_W-1:0] blue
);
   localparam int XW = $clog2(SIZE_X);
   localparam int YW = $clog2(SIZE_Y);
   localparam int SW = DATA_W + 2;
   localparam logic [XW-1:0] X_LAST = XW'(SIZE_X - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(SIZE_Y - 1);
   localparam logic RED_X = 1'(PATTERN % 2);
   localparam logic RED_Y = 1'((PATTERN / 2) % 2);

   typedef enum logic [1:0] {FILL, RUN, EOL, FLUSH} state_t;
   state_t state, state_nx;

   logic [XW-1:0] ix;
   logic [YW-1:0] iy;
   logic [YW-1:0] orow;
   logic [1:0]    wslot;
   logic [1:0]    oslot;
   logic          accept;
   logic          restart;
   logic          kill;
   logic          emit;
   logic [XW-1:0] emit_x;

   // Row r of the frame lives in slot r mod 3; slots rotate instead of shifting data.
   logic [DATA_W-1:0] line_mem [3][SIZE_X];

   function automatic logic [1:0] slot_inc(input logic [1:0] s);
      return (s == 2'd2) ? 2'd0 : s + 2'd1;
   endfunction

   function automatic logic [1:0] slot_dec(input logic [1:0] s);
      return (s == 2'd0) ? 2'd2 : s - 2'd1;
   endfunction

   assign accept  = in_valid && in_ready;
   assign restart = accept && in_sof;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= FILL;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         FILL:    if (accept && !in_sof && ix == X_LAST) state_nx = RUN;
         RUN:     if (restart) state_nx = FILL;
                  else if (accept && ix == X_LAST) state_nx = EOL;
         EOL:     state_nx = (iy == Y_LAST) ? FLUSH : RUN;
         FLUSH:   if (ix == X_LAST) state_nx = FILL;
         default: state_nx = FILL;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      emit     = 1'b0;
      emit_x   = ix;
      kill     = 1'b0;
      case (state)
         FILL:  in_ready = 1'b1;
         RUN: begin
            in_ready = 1'b1;
            emit     = accept && !in_sof && (ix != '0);
            emit_x   = ix - XW'(1);
            kill     = restart;
         end
         EOL: begin
            emit   = 1'b1;
            emit_x = X_LAST;
         end
         FLUSH: emit = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ix    <= '0;
         iy    <= '0;
         wslot <= 2'd0;
         orow  <= '0;
         oslot <= 2'd0;
      end else if (restart) begin
         ix    <= XW'(1);
         iy    <= '0;
         wslot <= 2'd0;
      end else begin
         case (state)
            FILL: if (accept) begin
               if (ix == X_LAST) begin
                  ix    <= '0;
                  iy    <= YW'(1);
                  wslot <= 2'd1;
                  orow  <= '0;
                  oslot <= 2'd0;
               end else begin
                  ix <= ix + XW'(1);
               end
            end
            RUN: if (accept && ix != X_LAST) ix <= ix + XW'(1);
            EOL: begin
               ix    <= '0;
               orow  <= orow + YW'(1);
               oslot <= slot_inc(oslot);
               if (iy != Y_LAST) begin
                  iy    <= iy + YW'(1);
                  wslot <= slot_inc(wslot);
               end
            end
            FLUSH: begin
               if (ix == X_LAST) begin
                  ix    <= '0;
                  iy    <= '0;
                  wslot <= 2'd0;
               end else begin
                  ix <= ix + XW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (accept) line_mem[restart ? 2'd0 : wslot][restart ? '0 : ix] <= raw;
   end

   logic          v1;
   logic [XW-1:0] x1;
   logic [YW-1:0] y1;
   logic [1:0]    sc1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         v1  <= 1'b0;
         x1  <= '0;
         y1  <= '0;
         sc1 <= 2'd0;
      end else begin
         v1 <= emit;
         if (emit) begin
            x1  <= emit_x;
            y1  <= orow;
            sc1 <= oslot;
         end
      end
   end

   // Edge taps mirror across the border pixel so neighbours keep the same Bayer colour.
   logic [XW-1:0] xw, xe;
   logic [1:0]    sn, ss;
   assign xw = (x1 == '0)     ? XW'(1)            : x1 - XW'(1);
   assign xe = (x1 == X_LAST) ? X_LAST - XW'(1)   : x1 + XW'(1);
   assign sn = (y1 == '0)     ? slot_inc(sc1)     : slot_dec(sc1);
   assign ss = (y1 == Y_LAST) ? slot_dec(sc1)     : slot_inc(sc1);

   logic v2, sof2, eol2, px2, py2;
   logic [DATA_W-1:0] t_nw, t_n, t_ne, t_w, t_c, t_e, t_sw, t_s, t_se;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         v2   <= 1'b0;
         sof2 <= 1'b0;
         eol2 <= 1'b0;
         px2  <= 1'b0;
         py2  <= 1'b0;
      end else begin
         v2   <= v1 && !kill;
         sof2 <= (x1 == '0) && (y1 == '0);
         eol2 <= (x1 == X_LAST);
         px2  <= x1[0] ^ RED_X;
         py2  <= y1[0] ^ RED_Y;
      end
   end

   always_ff @(posedge clock) begin
      t_nw <= line_mem[sn][xw];
      t_n  <= line_mem[sn][x1];
      t_ne <= line_mem[sn][xe];
      t_w  <= line_mem[sc1][xw];
      t_c  <= line_mem[sc1][x1];
      t_e  <= line_mem[sc1][xe];
      t_sw <= line_mem[ss][xw];
      t_s  <= line_mem[ss][x1];
      t_se <= line_mem[ss][xe];
   end

   logic [SW-1:0]     sum_orth, sum_diag, sum_ew, sum_ns;
   logic [DATA_W-1:0] avg_orth, avg_diag, avg_ew, avg_ns;
   logic [DATA_W-1:0] red_c, green_c, blue_c;

   assign sum_orth = SW'(t_n) + SW'(t_s) + SW'(t_e) + SW'(t_w);
   assign sum_diag = SW'(t_nw) + SW'(t_ne) + SW'(t_sw) + SW'(t_se);
   assign sum_ew   = SW'(t_e) + SW'(t_w);
   assign sum_ns   = SW'(t_n) + SW'(t_s);
   assign avg_orth = DATA_W'(sum_orth >> 2);
   assign avg_diag = DATA_W'(sum_diag >> 2);
   assign avg_ew   = DATA_W'(sum_ew >> 1);
   assign avg_ns   = DATA_W'(sum_ns >> 1);

   // {py2,px2}: 00 red site, 11 blue site, 01 green on red row, 10 green on blue row.
   always_comb begin
      red_c   = t_c;
      green_c = avg_orth;
      blue_c  = avg_diag;
      case ({py2, px2})
         2'b11: begin
            red_c   = avg_diag;
            green_c = avg_orth;
            blue_c  = t_c;
         end
         2'b01: begin
            red_c   = avg_ew;
            green_c = t_c;
            blue_c  = avg_ns;
         end
         2'b10: begin
            red_c   = avg_ns;
            green_c = t_c;
            blue_c  = avg_ew;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         red       <= '0;
         green     <= '0;
         blue      <= '0;
      end else begin
         out_valid <= v2 && !kill;
         out_sof   <= v2 && !kill && sof2;
         out_eol   <= v2 && !kill && eol2;
         if (v2 && !kill) begin
            red   <= red_c;
            green <= green_c;
            blue  <= blue_c;
         end
      end
   end
endmodule
